// File: rtl/ad_sampler_pkg.sv
// Shared definitions for the ADC acquisition front end: data width,
// FSM state encoding and a channel-index width helper.
package ad_sampler_pkg;

  localparam int AD_DATA_NBIT = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONV   = 3'd1,
    ST_WAIT_H = 3'd2,
    ST_WAIT_L = 3'd3,
    ST_RD_LO  = 3'd4,
    ST_RD_HI  = 3'd5
  } state_t;

  // Width of a channel index; a single-channel build still needs one bit.
  function automatic int chan_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ad_sampler_if.sv
// ADC pin bundle plus the cache write port fed by the sampler.
interface ad_sampler_if import ad_sampler_pkg::*; #(
  parameter int CH_NUM = 8
) ();

  localparam int CHW = chan_width(CH_NUM);

  logic                    ad_busy;
  logic [AD_DATA_NBIT-1:0] ad_data;
  logic                    ad_convst;
  logic                    ad_cs_n;
  logic                    ad_rd_n;
  logic                    wr;
  logic [AD_DATA_NBIT-1:0] wdata;
  logic [CHW-1:0]          chan;
  logic                    frame_start;

  // The sampler drives the ADC strobes and the cache write port.
  modport master (
    input  ad_busy, ad_data,
    output ad_convst, ad_cs_n, ad_rd_n, wr, wdata, chan, frame_start
  );

  // The ADC and cache side.
  modport slave (
    output ad_busy, ad_data,
    input  ad_convst, ad_cs_n, ad_rd_n, wr, wdata, chan, frame_start
  );

endinterface

// File: rtl/ad_sync2.sv
// Two-flop level synchroniser for asynchronous ADC status lines.
module ad_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous level through two flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so the second flop takes the first flop's pre-edge value.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ad_sampler.sv
// Acquisition front end: paces conversions of a parallel SAR ADC, reads
// CH_NUM channels per conversion and emits one cache write per channel.
module ad_sampler import ad_sampler_pkg::*; #(
  parameter int CH_NUM   = 8,
  parameter int PERIOD   = 1000,
  parameter int CONV_LO  = 2,
  parameter int RD_LO    = 3,
  parameter int RD_HI    = 2,
  parameter int BUSY_TMO = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  ad_sampler_if.master  bus,
  output logic          overrun,
  output logic          tmo_err
);

  localparam int CHW    = chan_width(CH_NUM);
  localparam int PW     = $clog2(PERIOD);
  localparam int TW     = $clog2(BUSY_TMO + 1);
  localparam int PH_MAX = (CONV_LO > RD_LO) ? ((CONV_LO > RD_HI) ? CONV_LO : RD_HI)
                                            : ((RD_LO > RD_HI) ? RD_LO : RD_HI);
  localparam int PHW    = $clog2(PH_MAX + 1);

  logic          busy_s;
  logic [PW-1:0] per_cnt;
  logic          tick;

  state_t                  state_q, state_d;
  logic [PHW-1:0]          ph_q, ph_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [CHW-1:0]          chan_q, chan_d;
  logic                    convst_q, convst_d;
  logic                    cs_n_q, cs_n_d;
  logic                    rd_n_q, rd_n_d;
  logic                    wr_q, wr_d;
  logic                    fs_q, fs_d;
  logic [AD_DATA_NBIT-1:0] wdata_q, wdata_d;
  logic                    overrun_q, overrun_d;
  logic                    tmo_err_q, tmo_err_d;

  ad_sync2 u_busy_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.ad_busy),
    .q   (busy_s)
  );

  assign tick = en && (per_cnt == PW'(PERIOD - 1));

  // Sample-period counter: free-runs 0..PERIOD-1 while enabled, held at 0 otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt <= '0;
    end else if (!en || tick) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + 1'b1;
    end
  end

  // FSM and output registers; every output is a flop so no input reaches an output combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ph_q      <= '0;
      tmo_q     <= '0;
      chan_q    <= '0;
      convst_q  <= 1'b1;
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_q      <= 1'b0;
      fs_q      <= 1'b0;
      wdata_q   <= '0;
      overrun_q <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      tmo_q     <= tmo_d;
      chan_q    <= chan_d;
      convst_q  <= convst_d;
      cs_n_q    <= cs_n_d;
      rd_n_q    <= rd_n_d;
      wr_q      <= wr_d;
      fs_q      <= fs_d;
      wdata_q   <= wdata_d;
      overrun_q <= overrun_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  // Next-state and next-output decode; strobes wr/frame_start/tmo_err default low each cycle.
  always_comb begin
    // NOTE: every signal gets its default first, so no branch can leave one unassigned and infer a latch.
    state_d   = state_q;
    ph_d      = ph_q;
    tmo_d     = tmo_q;
    chan_d    = chan_q;
    convst_d  = convst_q;
    cs_n_d    = cs_n_q;
    rd_n_d    = rd_n_q;
    wr_d      = 1'b0;
    fs_d      = 1'b0;
    wdata_d   = wdata_q;
    tmo_err_d = 1'b0;
    overrun_d = overrun_q | (tick && (state_q != ST_IDLE));

    unique case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d  = ST_CONV;
          convst_d = 1'b0;
          ph_d     = '0;
        end
      end
      ST_CONV: begin
        if (ph_q == PHW'(CONV_LO - 1)) begin
          state_d  = ST_WAIT_H;
          convst_d = 1'b1;
          tmo_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      ST_WAIT_H: begin
        if (busy_s) begin
          state_d = ST_WAIT_L;
          tmo_d   = '0;
        end else if (tmo_q == TW'(BUSY_TMO - 1)) begin
          state_d   = ST_IDLE;
          tmo_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_WAIT_L: begin
        if (!busy_s) begin
          state_d = ST_RD_LO;
          cs_n_d  = 1'b0;
          rd_n_d  = 1'b0;
          chan_d  = '0;
          ph_d    = '0;
        end else if (tmo_q == TW'(BUSY_TMO - 1)) begin
          state_d   = ST_IDLE;
          tmo_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_RD_LO: begin
        // Data is captured on the last low cycle, while the ADC still drives it.
        if (ph_q == PHW'(RD_LO - 1)) begin
          state_d = ST_RD_HI;
          rd_n_d  = 1'b1;
          wr_d    = 1'b1;
          fs_d    = (chan_q == '0);
          wdata_d = bus.ad_data;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      ST_RD_HI: begin
        if (ph_q == PHW'(RD_HI - 1)) begin
          ph_d = '0;
          if (chan_q != CHW'(CH_NUM - 1)) begin
            state_d = ST_RD_LO;
            chan_d  = chan_q + 1'b1;
            rd_n_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
            cs_n_d  = 1'b1;
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.ad_convst   = convst_q;
  assign bus.ad_cs_n     = cs_n_q;
  assign bus.ad_rd_n     = rd_n_q;
  assign bus.wr          = wr_q;
  assign bus.wdata       = wdata_q;
  assign bus.chan        = chan_q;
  assign bus.frame_start = fs_q;
  assign overrun         = overrun_q;
  assign tmo_err         = tmo_err_q;

endmodule

// File: tb/tb_ad_sampler.sv
// Directed bench for ad_sampler: nominal frame, pacing, BUSY timeout,
// async reset mid-read, en drop mid-frame, and overrun on a fast instance.
module tb_ad_sampler;
  import ad_sampler_pkg::*;

  logic clk = 1'b0;
  logic rst, en, en2;
  logic overrun, tmo_err, overrun2, tmo_err2;

  int n_checks = 0;
  int n_errors = 0;
  int busy_len = 20;

  always #5 clk = ~clk;

  ad_sampler_if #(.CH_NUM(8)) bif ();
  ad_sampler_if #(.CH_NUM(8)) bif2 ();

  ad_sampler #(.CH_NUM(8), .PERIOD(100)) u_dut (
    .clk (clk), .rst (rst), .en (en), .bus (bif),
    .overrun (overrun), .tmo_err (tmo_err)
  );

  ad_sampler #(.CH_NUM(8), .PERIOD(16)) u_ovr (
    .clk (clk), .rst (rst), .en (en2), .bus (bif2),
    .overrun (overrun2), .tmo_err (tmo_err2)
  );

  // ADC data model: word index advances after each completed read, restarts when CS is released.
  logic [15:0] rd_idx;
  logic        rd_prev;
  always @(posedge clk) begin
    if (bif.ad_cs_n) rd_idx <= 16'd0;
    else if (rd_prev == 1'b0 && bif.ad_rd_n == 1'b1) rd_idx <= rd_idx + 16'd1;
    rd_prev <= bif.ad_rd_n;
  end
  assign bif.ad_data  = 16'h0100 + rd_idx;
  assign bif2.ad_data = 16'h0200;

  // ADC BUSY model: rises 3 clocks after CONVST rises, stays high busy_len clocks.
  initial begin
    bif.ad_busy = 1'b0;
    forever begin
      @(posedge bif.ad_convst);
      if (rst === 1'b0 && busy_len > 0) begin
        repeat (3) @(negedge clk);
        bif.ad_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        bif.ad_busy = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stimulus bookkeeping
  int          fall_at [10];
  int          wr_at   [8];
  int          wr_chan [8];
  bit          wr_fs   [8];
  logic [15:0] wr_data [8];
  int n_falls, n_wr, conv_low, rd_low, cs_falls, rd_outside, wr_outside, fs_stray;
  int n, wr_cnt, first_chan, last_chan;
  logic [15:0] first_data, last_data;
  logic prev_convst, prev_cs;
  bit seen;

  initial begin
    rst = 1'b1; en = 1'b0; en2 = 1'b0; bif2.ad_busy = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_convst",  bif.ad_convst, 1);
    check("rst_cs_n",    bif.ad_cs_n, 1);
    check("rst_rd_n",    bif.ad_rd_n, 1);
    check("rst_wr",      bif.wr, 0);
    check("rst_wdata",   bif.wdata, 0);
    check("rst_chan",    bif.chan, 0);
    check("rst_fs",      bif.frame_start, 0);
    check("rst_overrun", overrun, 0);
    check("rst_tmo",     tmo_err, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_convst", bif.ad_convst, 1);

    // Nominal frame and periodic pacing: en high for 1000 clocks
    n_falls = 0; n_wr = 0; conv_low = 0; rd_low = 0; cs_falls = 0;
    rd_outside = 0; wr_outside = 0; fs_stray = 0;
    prev_convst = 1'b1; prev_cs = 1'b1;
    en = 1'b1;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      if (prev_convst && !bif.ad_convst) begin
        if (n_falls < 10) fall_at[n_falls] = c;
        n_falls++;
      end
      if (c < 200) begin
        if (!bif.ad_convst) conv_low++;
        if (!bif.ad_rd_n) rd_low++;
        if (prev_cs && !bif.ad_cs_n) cs_falls++;
        if (!bif.ad_rd_n && bif.ad_cs_n) rd_outside++;
      end
      prev_convst = bif.ad_convst;
      prev_cs     = bif.ad_cs_n;
      if (bif.wr) begin
        if (bif.ad_cs_n) wr_outside++;
        if (n_wr < 8) begin
          wr_at[n_wr]   = c;
          wr_data[n_wr] = bif.wdata;
          wr_chan[n_wr] = int'(bif.chan);
          wr_fs[n_wr]   = bif.frame_start;
        end
        n_wr++;
      end else if (bif.frame_start) begin
        fs_stray++;
      end
    end
    en = 1'b0;
    check("pace_falls", n_falls, 10);
    for (int i = 0; i < 10; i++) check("pace_fall_at", fall_at[i], 100 * (i + 1));
    check("pace_overrun", overrun, 0);
    check("nom_convst_low", conv_low, 2);
    check("nom_rd_low", rd_low, 24);
    check("nom_cs_falls", cs_falls, 1);
    check("nom_rd_outside_cs", rd_outside, 0);
    check("nom_wr_outside_cs", wr_outside, 0);
    check("nom_fs_stray", fs_stray, 0);
    check("nom_total_wr", n_wr, 72);
    for (int i = 0; i < 8; i++) begin
      check("nom_wdata", wr_data[i], 32'h100 + i);
      check("nom_chan", wr_chan[i], i);
      check("nom_fs", wr_fs[i], (i == 0) ? 1 : 0);
      if (i > 0) check("nom_spacing", wr_at[i] - wr_at[i-1], 5);
    end
    repeat (200) @(negedge clk);

    // BUSY timeout: BUSY never rises
    busy_len = 0;
    en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 150 && !seen; i++) begin @(negedge clk); if (!bif.ad_convst) seen = 1'b1; end
    check("tmo_conv_start", seen, 1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); if (bif.ad_convst) seen = 1'b1; end
    check("tmo_conv_end", seen, 1);
    n = 0; wr_cnt = 0; seen = 1'b0;
    while (!seen && n < 5000) begin
      @(negedge clk);
      n++;
      if (bif.wr) wr_cnt++;
      if (tmo_err) seen = 1'b1;
    end
    check("tmo_delay", n, 4096);
    check("tmo_no_wr", wr_cnt, 0);
    busy_len = 20;
    @(negedge clk);
    check("tmo_pulse_width", tmo_err, 0);
    seen = 1'b0;
    for (int i = 0; i < 150 && !seen; i++) begin @(negedge clk); if (!bif.ad_convst) seen = 1'b1; end
    check("tmo_next_conv", seen, 1);
    en = 1'b0;
    repeat (150) @(negedge clk);

    // Async reset during RD_LO of channel 3
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin @(negedge clk); if (bif.wr && bif.chan == 3'd2) seen = 1'b1; end
    check("arst_reach_ch2", seen, 1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); if (!bif.ad_rd_n) seen = 1'b1; end
    check("arst_pre_rd_n", bif.ad_rd_n, 0);
    check("arst_pre_cs_n", bif.ad_cs_n, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_rd_n", bif.ad_rd_n, 1);
    check("arst_cs_n", bif.ad_cs_n, 1);
    check("arst_convst", bif.ad_convst, 1);
    check("arst_wr", bif.wr, 0);
    check("arst_chan", bif.chan, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin @(negedge clk); if (bif.wr) seen = 1'b1; end
    check("arst_next_wr", seen, 1);
    check("arst_next_chan", bif.chan, 0);
    check("arst_next_fs", bif.frame_start, 1);
    check("arst_next_wdata", bif.wdata, 32'h100);

    // en dropped during channel 2 of the same frame
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); if (bif.wr) seen = 1'b1; end
    check("endrop_ch1_wr", seen, 1);
    check("endrop_ch1_chan", bif.chan, 1);
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin @(negedge clk); if (!bif.ad_rd_n) seen = 1'b1; end
    check("endrop_ch2_rd", seen, 1);
    en = 1'b0;
    wr_cnt = 0; n_falls = 0; prev_convst = bif.ad_convst;
    first_chan = -1; last_chan = -1; first_data = '0; last_data = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (prev_convst && !bif.ad_convst) n_falls++;
      prev_convst = bif.ad_convst;
      if (bif.wr) begin
        if (wr_cnt == 0) begin first_chan = int'(bif.chan); first_data = bif.wdata; end
        last_chan = int'(bif.chan); last_data = bif.wdata;
        wr_cnt++;
      end
    end
    check("endrop_wr_count", wr_cnt, 6);
    check("endrop_first_chan", first_chan, 2);
    check("endrop_first_data", first_data, 32'h102);
    check("endrop_last_chan", last_chan, 7);
    check("endrop_last_data", last_data, 32'h107);
    check("endrop_no_conv", n_falls, 0);

    // Overrun on the PERIOD=16 instance with BUSY held 30 clocks
    en2 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin @(negedge clk); if (!bif2.ad_convst) seen = 1'b1; end
    check("ovr_first_conv", seen, 1);
    check("ovr_clear_at_first_tick", overrun2, 0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); if (bif2.ad_convst) seen = 1'b1; end
    check("ovr_conv_end", seen, 1);
    repeat (3) @(negedge clk);
    bif2.ad_busy = 1'b1;
    repeat (30) @(negedge clk);
    bif2.ad_busy = 1'b0;
    check("ovr_set", overrun2, 1);
    wr_cnt = 0;
    for (int i = 0; i < 200 && wr_cnt < 8; i++) begin
      @(negedge clk);
      if (bif2.wr) begin
        check("ovr_chan", bif2.chan, wr_cnt);
        check("ovr_fs", bif2.frame_start, (wr_cnt == 0) ? 1 : 0);
        check("ovr_wdata", bif2.wdata, 32'h200);
        wr_cnt++;
      end
    end
    en2 = 1'b0;
    check("ovr_wr_count", wr_cnt, 8);
    check("ovr_sticky", overrun2, 1);
    check("ovr_no_tmo", tmo_err2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ad_sampler.md
Name: ad_sampler

Overview:
- Acquisition front end that drives a parallel-output, multi-channel SAR ADC with CONVST/BUSY/CS/RD.
- Produces a write strobe plus sample word that feed the ping-pong cache write port directly: wr maps to cache wr, wdata maps to cache wdata, and clk is the cache wclk.
- Samples CH_NUM channels per conversion, paced by a programmable sample-period counter.

Parameters:
- CH_NUM, 8, channels read per conversion (1..16).
- PERIOD, 1000, clocks between conversion starts (>= frame length, min 16).
- CONV_LO, 2, clocks ad_convst is held low.
- RD_LO, 3, clocks ad_rd_n is low per channel read.
- RD_HI, 2, clocks ad_rd_n is high between reads.
- BUSY_TMO, 4096, clocks allowed for BUSY to rise and then fall.

Ports:
- clk  in  1  system clock; same domain as the cache write clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  enables the sample-period counter.
- ad_busy  in  1  ADC BUSY; asynchronous, so it is synchronised internally.
- ad_data  in  `AD_DATA_NBIT  ADC parallel data bus.
- ad_convst  out  1  conversion start; idles high, pulses low.
- ad_cs_n  out  1  ADC chip select, active low.
- ad_rd_n  out  1  ADC read strobe, active low.
- wr  out  1  one-cycle write strobe to the cache.
- wdata  out  `AD_DATA_NBIT  captured sample; valid while wr=1.
- chan  out  CHW=$clog2(CH_NUM)  channel index of wdata.
- frame_start  out  1  high with wr for channel 0.
- overrun  out  1  sticky; set when a period tick arrives while a frame is active.
- tmo_err  out  1  one-cycle pulse on BUSY timeout.

Behaviour:
- Reset values: ad_convst=1, ad_cs_n=1, ad_rd_n=1, wr=0, wdata=0, chan=0, frame_start=0, overrun=0, tmo_err=0, FSM=IDLE, all counters=0.
- ad_busy passes through a 2-FF synchroniser; busy_s is the synchronised level (2-cycle latency).
- Period counter runs only while en=1: counts 0..PERIOD-1, asserts tick for one cycle at PERIOD-1, then wraps. en=0 clears it to 0.
- The first tick occurs PERIOD clocks after en rises.
- FSM states and transitions:
  - IDLE: on tick -> CONV, with ad_convst=0 and conv counter=0.
  - CONV: after CONV_LO cycles -> WAIT_H, with ad_convst=1.
  - WAIT_H: busy_s=1 -> WAIT_L. Timeout counter reaching BUSY_TMO -> IDLE with tmo_err pulse.
  - WAIT_L: busy_s=0 -> RD_LO, with ad_cs_n=0, ad_rd_n=0, chan counter=0. Timeout as in WAIT_H.
  - RD_LO: ad_rd_n=0 for RD_LO cycles. On the last cycle, ad_data is registered into wdata, wr=1 next cycle, and the transition is -> RD_HI with ad_rd_n=1.
  - RD_HI: ad_rd_n=1 for RD_HI cycles. If chan < CH_NUM-1, increment chan and -> RD_LO. Otherwise -> IDLE with ad_cs_n=1.
- The timeout counter is shared by WAIT_H and WAIT_L and resets on entry to each.
- Exactly CH_NUM wr pulses per good frame, chan ascending 0..CH_NUM-1. frame_start accompanies chan=0 only.
- wr is never asserted in consecutive cycles; spacing is RD_LO+RD_HI clocks.
- A tick while FSM != IDLE: the tick is dropped and overrun is set, cleared only by rst.
- en deasserted mid-frame: the current frame completes and no new tick is generated.
- Timeout: no wr is issued for that conversion, and overrun is unaffected.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous). ad_cs_n/ad_rd_n deassert the same instant.
- No combinational path from any input to any output.

Decomposition:
- Shared globals provide AD_DATA_NBIT and the FSM state encoding constants (IDLE, CONV, WAIT_H, WAIT_L, RD_LO, RD_HI, 3-bit).
- One sub-module, ad_sync2: a 2-FF level synchroniser with async active-high reset to 0, reusable for other ADC status lines.

Test Plan:
- Nominal frame:
  - Stimulus: PERIOD=100, CH_NUM=8; model asserts BUSY 3 clocks after CONVST rises for 20 clocks; data = 0x100+ch.
  - Required: 8 wr pulses with wdata 0x100..0x107, chan 0..7, frame_start only on the first, spacing 5 clocks, ad_convst low exactly 2 clocks, ad_cs_n low across all reads.
- Periodic pacing:
  - Stimulus: en=1 for 1000 clocks.
  - Required: ad_convst falling edges exactly 100 clocks apart, first one at clock 100 after en; overrun=0.
- Overrun:
  - Stimulus: PERIOD=16, BUSY held high 30 clocks.
  - Required: overrun=1 after the second tick; the first frame still delivers all 8 samples.
- BUSY timeout:
  - Stimulus: BUSY never rises.
  - Required: tmo_err pulses once 4096 clocks after WAIT_H entry; no wr; the FSM returns to IDLE and the next tick starts a new conversion.
- Async reset mid-read:
  - Stimulus: assert rst during RD_LO of channel 3.
  - Required: ad_rd_n, ad_cs_n, ad_convst=1 and wr=0 without waiting for a clock edge; after release with en=1, the next frame starts at chan 0.
- en drop mid-frame:
  - Stimulus: deassert en during channel 2.
  - Required: channels 2..7 still written, then no further ad_convst pulses.
